// File: rtl/bru_pkg.sv
// Shared types and defaults for the branch resolve unit.
// The prediction queue holds one pred_entry_t per in-flight branch/jump.
package bru_pkg;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } bru_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            taken;
        logic [XLEN-1:0] target;
    } pred_entry_t;
endpackage

// File: rtl/bru_pred_fifo.sv
// In-flight prediction queue: FIFO of pred_entry_t with synchronous clear.
// Clear wins over a same-cycle push and pop.
module bru_pred_fifo
    import bru_pkg::*;
#(
    parameter int DEPTH = bru_pkg::DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  pred_entry_t              push_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output pred_entry_t              head
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    pred_entry_t   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// Compares EX-stage branch resolutions against queued fetch predictions,
// trains the predictor, and sequences redirect/flush on a mispredict.
//   state | meaning
//   IDLE  | accepting predictions and resolutions
//   FLUSH | redirect+flush asserted for one cycle, queue emptied
//   DRAIN | two quiet cycles while the pipeline refills
module branch_resolve_unit #(
    parameter int XLEN  = bru_pkg::XLEN,
    parameter int DEPTH = bru_pkg::DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pred_valid,
    input  logic [XLEN-1:0] pred_pc,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_target,
    output logic            pred_ready,
    input  logic            res_valid,
    input  logic [XLEN-1:0] res_pc,
    input  logic            res_is_jump,
    input  logic            res_taken,
    input  logic [XLEN-1:0] res_target,
    output logic            upd_valid,
    output logic            upd_taken,
    output logic [XLEN-1:0] upd_pc,
    output logic [XLEN-1:0] upd_target,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic [15:0]     branch_cnt,
    output logic [15:0]     mispredict_cnt
);
    import bru_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    bru_state_t        state, state_next;
    logic              drain_cnt, drain_cnt_next;
    pred_entry_t       head;
    logic              full, empty;
    logic [CW-1:0]     count, count_next;
    logic              push, pop_ok, clear;
    logic              accept_res, act_taken, mispredict, miss;
    logic              ready_next;
    logic [15:0]       branch_cnt_q, mispredict_cnt_q;

    assign act_taken  = res_taken | res_is_jump;
    assign accept_res = res_valid && (state == IDLE);
    assign push       = pred_valid && pred_ready && !full;
    assign pop_ok     = accept_res && !empty;
    assign miss       = accept_res && mispredict;
    assign clear      = miss || (state == FLUSH);

    // An empty queue behaves as an implicit not-taken prediction at res_pc.
    always_comb begin
        mispredict = act_taken;
        if (!empty) begin
            mispredict = (head.pc != res_pc) || (head.taken != act_taken) ||
                         (head.taken && act_taken && (head.target != res_target));
        end
    end

    bru_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ('{pc: pred_pc, taken: pred_taken, target: pred_target}),
        .pop       (accept_res),
        .clear     (clear),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .head      (head)
    );

    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        case (state)
            IDLE:  if (miss) state_next = FLUSH;
            FLUSH: begin
                state_next     = DRAIN;
                drain_cnt_next = 1'b1;
            end
            DRAIN: begin
                if (drain_cnt == 1'b0) state_next = IDLE;
                else                   drain_cnt_next = drain_cnt - 1'b1;
            end
            default: state_next = IDLE;
        endcase
        count_next = clear ? '0 : count + CW'(push) - CW'(pop_ok);
        ready_next = (state_next == IDLE) && (count_next < CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            drain_cnt        <= 1'b0;
            pred_ready       <= 1'b0;
            upd_valid        <= 1'b0;
            upd_taken        <= 1'b0;
            upd_pc           <= '0;
            upd_target       <= '0;
            redirect         <= 1'b0;
            flush            <= 1'b0;
            redirect_pc      <= '0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            state      <= state_next;
            drain_cnt  <= drain_cnt_next;
            pred_ready <= ready_next;
            upd_valid  <= accept_res;
            upd_taken  <= accept_res && act_taken;
            redirect   <= (state_next == FLUSH);
            flush      <= (state_next == FLUSH);
            if (accept_res) begin
                upd_pc     <= res_pc;
                upd_target <= res_target;
                if (branch_cnt_q != 16'hFFFF) branch_cnt_q <= branch_cnt_q + 16'd1;
            end
            if (miss) begin
                redirect_pc <= act_taken ? res_target : res_pc + XLEN'(4);
                if (mispredict_cnt_q != 16'hFFFF) mispredict_cnt_q <= mispredict_cnt_q + 16'd1;
            end
        end
    end

    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit.
// Inputs change 1 time unit after the rising edge; outputs sampled there too.
module tb_branch_resolve_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pred_valid, pred_taken, pred_ready;
    logic [31:0] pred_pc, pred_target;
    logic        res_valid, res_is_jump, res_taken;
    logic [31:0] res_pc, res_target;
    logic        upd_valid, upd_taken, redirect, flush;
    logic [31:0] upd_pc, upd_target, redirect_pc;
    logic [15:0] branch_cnt, mispredict_cnt;

    int checks = 0;
    int failures = 0;
    int exp_br = 0;
    int exp_mp = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(32), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .pred_ready(pred_ready),
        .res_valid(res_valid), .res_pc(res_pc), .res_is_jump(res_is_jump),
        .res_taken(res_taken), .res_target(res_target),
        .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_pc(upd_pc),
        .upd_target(upd_target), .redirect(redirect), .redirect_pc(redirect_pc),
        .flush(flush), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    task automatic drive(input logic pv, input logic [31:0] ppc, input logic pt,
                         input logic [31:0] ptgt, input logic rv, input logic [31:0] rpc,
                         input logic rj, input logic rt, input logic [31:0] rtgt);
        pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptgt;
        res_valid = rv; res_pc = rpc; res_is_jump = rj; res_taken = rt; res_target = rtgt;
        @(posedge clk);
        #1;
        pred_valid = 1'b0;
        res_valid  = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
        drive(1'b1, pc, t, tgt, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic j, input logic t, input logic [31:0] tgt);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, pc, j, t, tgt);
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (pred_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%0h exp=0", pred_ready); end
        checks++; if (upd_valid !== 1'b0 || redirect !== 1'b0 || flush !== 1'b0) begin failures++; $display("FAIL rst_pulses got=%0h%0h%0h exp=000", upd_valid, redirect, flush); end
        checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL rst_redirect_pc got=%0h exp=0", redirect_pc); end
        checks++; if (branch_cnt !== 16'h0 || mispredict_cnt !== 16'h0) begin failures++; $display("FAIL rst_cnt got=%0h/%0h exp=0/0", branch_cnt, mispredict_cnt); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (pred_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%0h exp=1", pred_ready); end
    endtask

    task automatic test_correct_taken();
        push(32'h100, 1'b1, 32'h200);
        resolve(32'h100, 1'b0, 1'b1, 32'h200); exp_br++;
        checks++; if (upd_valid !== 1'b1 || upd_taken !== 1'b1) begin failures++; $display("FAIL ok_upd got=%0h%0h exp=11", upd_valid, upd_taken); end
        checks++; if (upd_pc !== 32'h100 || upd_target !== 32'h200) begin failures++; $display("FAIL ok_upd_pc got=%0h/%0h exp=100/200", upd_pc, upd_target); end
        checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL ok_redirect got=%0h exp=0", redirect); end
        checks++; if (branch_cnt !== 16'(exp_br)) begin failures++; $display("FAIL ok_branch_cnt got=%0d exp=%0d", branch_cnt, exp_br); end
        idle();
        checks++; if (upd_valid !== 1'b0) begin failures++; $display("FAIL ok_upd_pulse got=%0h exp=0", upd_valid); end
    endtask

    task automatic test_direction_miss();
        push(32'h100, 1'b0, 32'h0);
        resolve(32'h100, 1'b0, 1'b1, 32'h180); exp_br++; exp_mp++;
        checks++; if (redirect !== 1'b1 || flush !== 1'b1) begin failures++; $display("FAIL dir_pulses got=%0h%0h exp=11", redirect, flush); end
        checks++; if (redirect_pc !== 32'h180) begin failures++; $display("FAIL dir_redirect_pc got=%0h exp=180", redirect_pc); end
        checks++; if (mispredict_cnt !== 16'(exp_mp)) begin failures++; $display("FAIL dir_mp_cnt got=%0d exp=%0d", mispredict_cnt, exp_mp); end
        checks++; if (pred_ready !== 1'b0) begin failures++; $display("FAIL dir_ready0 got=%0h exp=0", pred_ready); end
        for (int i = 1; i < 3; i++) begin
            idle();
            checks++; if (pred_ready !== 1'b0 || redirect !== 1'b0) begin failures++; $display("FAIL dir_quiet%0d got=%0h%0h exp=00", i, pred_ready, redirect); end
        end
        idle();
        checks++; if (pred_ready !== 1'b1) begin failures++; $display("FAIL dir_ready_back got=%0h exp=1", pred_ready); end
    endtask

    task automatic test_target_miss();
        push(32'h100, 1'b1, 32'h200);
        push(32'h104, 1'b0, 32'h0);
        push(32'h108, 1'b1, 32'h300);
        resolve(32'h100, 1'b0, 1'b1, 32'h240); exp_br++; exp_mp++;
        checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h240) begin failures++; $display("FAIL tgt_redirect got=%0h/%0h exp=1/240", redirect, redirect_pc); end
        resolve(32'h104, 1'b0, 1'b0, 32'h0);
        checks++; if (upd_valid !== 1'b0 || branch_cnt !== 16'(exp_br)) begin failures++; $display("FAIL tgt_ignore_flush got=%0h/%0d exp=0/%0d", upd_valid, branch_cnt, exp_br); end
        resolve(32'h108, 1'b0, 1'b1, 32'h300);
        checks++; if (upd_valid !== 1'b0 || mispredict_cnt !== 16'(exp_mp)) begin failures++; $display("FAIL tgt_ignore_drain got=%0h/%0d exp=0/%0d", upd_valid, mispredict_cnt, exp_mp); end
        idle();
        checks++; if (pred_ready !== 1'b1) begin failures++; $display("FAIL tgt_ready_back got=%0h exp=1", pred_ready); end
        resolve(32'h500, 1'b0, 1'b0, 32'h0); exp_br++;
        checks++; if (redirect !== 1'b0 || upd_valid !== 1'b1) begin failures++; $display("FAIL tgt_queue_empty got=%0h/%0h exp=0/1", redirect, upd_valid); end
    endtask

    task automatic test_full_simultaneous();
        logic [31:0] order [4];
        order[0] = 32'h30; order[1] = 32'h40; order[2] = 32'h50; order[3] = 32'h60;
        for (int i = 0; i < 4; i++) begin
            push(32'h10 * (i + 1), 1'b0, 32'h0);
            checks++; if (pred_ready !== (i < 3)) begin failures++; $display("FAIL full_fill%0d got=%0h exp=%0h", i, pred_ready, (i < 3)); end
        end
        push(32'h99, 1'b0, 32'h0);
        checks++; if (pred_ready !== 1'b0) begin failures++; $display("FAIL full_drop got=%0h exp=0", pred_ready); end
        resolve(32'h10, 1'b0, 1'b0, 32'h0); exp_br++;
        checks++; if (redirect !== 1'b0 || pred_ready !== 1'b1) begin failures++; $display("FAIL full_pop got=%0h/%0h exp=0/1", redirect, pred_ready); end
        drive(1'b1, 32'h50, 1'b0, 32'h0, 1'b1, 32'h20, 1'b0, 1'b0, 32'h0); exp_br++;
        checks++; if (redirect !== 1'b0 || pred_ready !== 1'b1) begin failures++; $display("FAIL full_pushpop got=%0h/%0h exp=0/1", redirect, pred_ready); end
        push(32'h60, 1'b0, 32'h0);
        checks++; if (pred_ready !== 1'b0) begin failures++; $display("FAIL full_count3 got=%0h exp=0", pred_ready); end
        for (int i = 0; i < 4; i++) begin
            resolve(order[i], 1'b0, 1'b0, 32'h0); exp_br++;
            checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL full_order%0d got=%0h exp=0", i, redirect); end
        end
        resolve(32'h700, 1'b0, 1'b0, 32'h0); exp_br++;
        checks++; if (redirect !== 1'b0 || branch_cnt !== 16'(exp_br)) begin failures++; $display("FAIL full_drained got=%0h/%0d exp=0/%0d", redirect, branch_cnt, exp_br); end
    endtask

    task automatic test_empty_resolve();
        resolve(32'h300, 1'b0, 1'b0, 32'h0); exp_br++;
        checks++; if (redirect !== 1'b0 || upd_valid !== 1'b1 || upd_taken !== 1'b0) begin failures++; $display("FAIL empty_nt got=%0h%0h%0h exp=010", redirect, upd_valid, upd_taken); end
        resolve(32'h300, 1'b0, 1'b1, 32'h400); exp_br++; exp_mp++;
        checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h400) begin failures++; $display("FAIL empty_t got=%0h/%0h exp=1/400", redirect, redirect_pc); end
        repeat (3) idle();
        resolve(32'h310, 1'b1, 1'b0, 32'h500); exp_br++; exp_mp++;
        checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h500 || upd_taken !== 1'b1) begin failures++; $display("FAIL empty_jump got=%0h/%0h/%0h exp=1/500/1", redirect, redirect_pc, upd_taken); end
        repeat (3) idle();
        push(32'h200, 1'b1, 32'h300);
        resolve(32'h200, 1'b0, 1'b0, 32'h0); exp_br++; exp_mp++;
        checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h204) begin failures++; $display("FAIL fallthru got=%0h/%0h exp=1/204", redirect, redirect_pc); end
        repeat (3) idle();
        checks++; if (branch_cnt !== 16'(exp_br) || mispredict_cnt !== 16'(exp_mp)) begin failures++; $display("FAIL cnt_totals got=%0d/%0d exp=%0d/%0d", branch_cnt, mispredict_cnt, exp_br, exp_mp); end
    endtask

    task automatic test_saturation_reset();
        force dut.branch_cnt_q = 16'hFFFF;
        force dut.mispredict_cnt_q = 16'hFFFF;
        #1;
        release dut.branch_cnt_q;
        release dut.mispredict_cnt_q;
        resolve(32'h800, 1'b0, 1'b1, 32'h900);
        checks++; if (mispredict_cnt !== 16'hFFFF || branch_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_cnt got=%0h/%0h exp=ffff/ffff", mispredict_cnt, branch_cnt); end
        checks++; if (redirect !== 1'b1) begin failures++; $display("FAIL sat_redirect got=%0h exp=1", redirect); end
        idle();
        reset = 1'b0;
        #1;
        checks++; if (pred_ready !== 1'b0 || upd_valid !== 1'b0 || redirect !== 1'b0 || flush !== 1'b0) begin failures++; $display("FAIL drain_rst_pulses got=%0h%0h%0h%0h exp=0000", pred_ready, upd_valid, redirect, flush); end
        checks++; if (redirect_pc !== 32'h0 || branch_cnt !== 16'h0 || mispredict_cnt !== 16'h0) begin failures++; $display("FAIL drain_rst_regs got=%0h/%0h/%0h exp=0/0/0", redirect_pc, branch_cnt, mispredict_cnt); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (pred_ready !== 1'b1 || redirect !== 1'b0) begin failures++; $display("FAIL drain_rst_release got=%0h/%0h exp=1/0", pred_ready, redirect); end
        resolve(32'h900, 1'b0, 1'b0, 32'h0);
        checks++; if (upd_valid !== 1'b1 || branch_cnt !== 16'd1) begin failures++; $display("FAIL post_rst_idle got=%0h/%0d exp=1/1", upd_valid, branch_cnt); end
    endtask

    initial begin
        pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0; pred_target = '0;
        res_valid = 1'b0; res_pc = '0; res_is_jump = 1'b0; res_taken = 1'b0; res_target = '0;
        #12;
        test_reset();
        test_correct_taken();
        test_direction_miss();
        test_target_miss();
        test_full_simultaneous();
        test_empty_resolve();
        test_saturation_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, address/PC width; DEPTH, default 4, in-flight prediction queue entries (power of 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 pred_valid  input  1  fetch issued a prediction for a branch/jump this cycle.
REQ-005 pred_pc  input  XLEN  PC of the predicted instruction.
REQ-006 pred_taken  input  1  predicted direction.
REQ-007 pred_target  input  XLEN  predicted next PC when taken.
REQ-008 pred_ready  output  1  prediction accepted this cycle (queue not full, FSM IDLE).
REQ-009 res_valid  input  1  EX stage resolves the oldest branch/jump this cycle.
REQ-010 res_pc  input  XLEN  PC of the resolved instruction.
REQ-011 res_is_jump  input  1  resolved instruction is an unconditional jump.
REQ-012 res_taken  input  1  actual direction (forced 1 when res_is_jump).
REQ-013 res_target  input  XLEN  actual taken target.
REQ-014 upd_valid, upd_taken  output  1 each  predictor training strobe and actual direction (drive ID_EX_Branch/Pcsrc of the predictor).
REQ-015 upd_pc, upd_target  output  XLEN each  training PC and actual target.
REQ-016 redirect  output  1  one-cycle pulse: fetch must load redirect_pc.
REQ-017 redirect_pc  output  XLEN  corrected next PC.
REQ-018 flush  output  1  one-cycle pulse: kill IF/ID wrong-path instructions.
REQ-019 branch_cnt, mispredict_cnt  output  16 each  saturating statistics counters.

Function
REQ-020 Queue SHALL be FIFO; push on pred_valid && pred_ready; pop on res_valid when non-empty; push and pop in the same cycle SHALL both occur, count unchanged.
REQ-021 pred_ready SHALL be 1 iff count < DEPTH and state == IDLE; pred_valid while pred_ready=0 is dropped.
REQ-022 Pointers SHALL wrap modulo DEPTH; full = count==DEPTH, empty = count==0.
REQ-023 On res_valid the head entry is compared: mispredict = head.pc != res_pc, or head.taken != res_taken, or (both taken and head.target != res_target).
REQ-024 res_valid with empty queue SHALL be treated as predicted not-taken with pc = res_pc; mispredict iff res_taken.
REQ-025 redirect_pc SHALL be res_taken ? res_target : res_pc + 4 (XLEN bits, carry discarded).
REQ-026 All outputs SHALL be registered; upd_*, redirect, flush appear exactly 1 cycle after the res_valid edge.
REQ-027 upd_valid SHALL pulse for every res_valid, with or without mispredict.
REQ-028 FSM states: IDLE, FLUSH, DRAIN. IDLE->FLUSH on mispredict; FLUSH->DRAIN after 1 cycle; DRAIN holds 2 cycles then ->IDLE.
REQ-029 In FLUSH, redirect and flush SHALL be 1 and the queue SHALL be emptied (younger entries are wrong-path), including any same-cycle push.
REQ-030 res_valid in FLUSH or DRAIN SHALL be ignored (no pop, no update, no count).
REQ-031 branch_cnt increments per accepted resolution; mispredict_cnt per mispredict; both saturate at 16'hFFFF.

Reset
REQ-032 While reset=0: queue empty, pointers 0, state IDLE, pred_ready 0, upd_*/redirect/flush 0, redirect_pc 0, counters 0.
REQ-033 Reset assertion mid-FLUSH/DRAIN SHALL abort immediately; pred_ready returns 1 on the first edge after reset release.

Structure
REQ-034 Package bru_pkg SHALL hold XLEN, DEPTH, state enum (IDLE/FLUSH/DRAIN), pred_entry struct {pc, taken, target}.
REQ-035 Queue SHALL be sub-module bru_pred_fifo (push/pop/clear, full/empty, head output); compare, FSM and counters in top.

Verification
REQ-036 Correct taken: push {0x100,1,0x200}; res {0x100,taken,0x200} -> next cycle upd_valid=1, upd_taken=1, redirect=0, branch_cnt=1.
REQ-037 Direction miss: push {0x100,0,-}; res {0x100,taken,0x180} -> redirect=1, redirect_pc=0x180, flush=1, mispredict_cnt=1, pred_ready=0 for 3 cycles.
REQ-038 Target miss with 3 queued: head {0x100,1,0x200}, res target 0x240 -> redirect_pc=0x240, queue empty after FLUSH, later resolutions ignored until IDLE.
REQ-039 Full/simultaneous: fill 4 entries -> pred_ready=0; push+pop same cycle at count 3 -> count stays 3, FIFO order preserved across wrap.
REQ-040 Empty resolve: res {0x300,not-taken} on empty queue -> no redirect; res {0x300,taken,0x400} -> redirect_pc=0x400.
REQ-041 Reset during DRAIN and counter saturation (force 0xFFFF, one more miss) -> all outputs 0 after reset; counter holds 0xFFFF.
